battleship_ctrl: RTL and testbench

BATTLESHIP_CTRL -- requirements
Module: battleship_ctrl

---
 rtl/battleship_pkg.sv | 9 +
 rtl/battleship_if.sv | 30 +++
 rtl/battleship_shot_checker.sv | 24 ++
 rtl/battleship_ctrl.sv | 69 ++++++
 tb/tb_battleship_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/battleship_pkg.sv
// battleship_pkg: shared FSM states, coordinate type, board size and ship layout.
package battleship_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_SHOT, CHECK, REPORT, DONE} state_t;
    typedef logic [3:0] coord_t;
    localparam int BOARD_DIM = 10;
    localparam int NUM_SHIPS = 4;
    localparam coord_t SHIP_X [NUM_SHIPS] = '{4'd2, 4'd3, 4'd6, 4'd7};
    localparam coord_t SHIP_Y [NUM_SHIPS] = '{4'd9, 4'd9, 4'd1, 4'd1};
endpackage

// File: rtl/battleship_if.sv
// battleship_if: player-side shot request and result bus of the controller.
// master drives start/shot_valid/x/y; slave returns readiness, one-hot result flags and score.
interface battleship_if;
    import battleship_pkg::*;
    logic start;
    logic shot_valid;
    coord_t x;
    coord_t y;
    logic shot_ready;
    logic result_valid;
    logic hit;
    logic nearmiss;
    logic miss;
    logic repeat_shot;
    logic bad_coord;
    logic [2:0] hit_count;
    logic [4:0] shots_left;
    logic game_over;
    logic win;
    modport master (
        output start, shot_valid, x, y,
        input shot_ready, result_valid, hit, nearmiss, miss, repeat_shot, bad_coord,
        input hit_count, shots_left, game_over, win
    );
    modport slave (
        input start, shot_valid, x, y,
        output shot_ready, result_valid, hit, nearmiss, miss, repeat_shot, bad_coord,
        output hit_count, shots_left, game_over, win
    );
endinterface

// File: rtl/battleship_shot_checker.sv
// shot_checker: combinational lookup of whether (x,y) is a ship cell or orthogonally next to one.
// Ports: x, y in; is_ship, is_adjacent out.
module shot_checker
    import battleship_pkg::*;
(
    input  coord_t x,
    input  coord_t y,
    output logic   is_ship,
    output logic   is_adjacent
);
    logic [4:0] xe, ye;
    assign xe = {1'b0, x};
    assign ye = {1'b0, y};
    // 5-bit arithmetic keeps the +1 neighbour test from wrapping at the coordinate edge
    always_comb begin
        is_ship = 1'b0;
        is_adjacent = 1'b0;
        for (int i = 0; i < NUM_SHIPS; i++) begin
            is_ship |= x == SHIP_X[i] && y == SHIP_Y[i];
            is_adjacent |= (x == SHIP_X[i] && (ye + 5'd1 == {1'b0, SHIP_Y[i]} || ye == {1'b0, SHIP_Y[i]} + 5'd1))
                        || (y == SHIP_Y[i] && (xe + 5'd1 == {1'b0, SHIP_X[i]} || xe == {1'b0, SHIP_X[i]} + 5'd1));
        end
    end
endmodule

// File: rtl/battleship_ctrl.sv
// battleship_ctrl: single-player battleship game controller.
// Ports: clock, reset (sync, active high); bus (slave) carries start, shot request,
// one-hot result pulse, hit_count, shots_left, game_over and win.
module battleship_ctrl
    import battleship_pkg::*;
#(
    parameter int MAX_SHOTS  = 20,
    parameter int SHIP_CELLS = 4
) (
    input logic clock,
    input logic reset,
    battleship_if.slave bus
);
    state_t state;
    coord_t lx, ly;
    logic [99:0] fired;
    logic [6:0] idx;
    logic is_ship, is_adj, bad, fresh;
    shot_checker u_chk (.x(lx), .y(ly), .is_ship(is_ship), .is_adjacent(is_adj));
    assign bad = lx > coord_t'(BOARD_DIM - 1) || ly > coord_t'(BOARD_DIM - 1);
    assign idx = {3'b0, ly} * 7'(BOARD_DIM) + {3'b0, lx};
    assign fresh = !bad && !fired[idx];
    assign bus.shot_ready = state == WAIT_SHOT;
    assign bus.game_over = state == DONE;
    assign bus.win = state == DONE && bus.hit_count == 3'(SHIP_CELLS);
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            fired <= '0;
            lx <= '0;
            ly <= '0;
            bus.hit_count <= '0;
            bus.shots_left <= '0;
            {bus.result_valid, bus.hit, bus.nearmiss, bus.miss, bus.repeat_shot, bus.bad_coord} <= '0;
        end else begin
            {bus.result_valid, bus.hit, bus.nearmiss, bus.miss, bus.repeat_shot, bus.bad_coord} <= '0;
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state <= WAIT_SHOT;
                    fired <= '0;
                    bus.hit_count <= '0;
                    bus.shots_left <= 5'(MAX_SHOTS);
                end
                WAIT_SHOT: if (bus.shot_valid) begin
                    lx <= bus.x;
                    ly <= bus.y;
                    state <= CHECK;
                end
                // flags and counters land together so REPORT shows the updated score
                CHECK: begin
                    bus.result_valid <= 1'b1;
                    bus.bad_coord <= bad;
                    bus.repeat_shot <= !bad && fired[idx];
                    bus.hit <= fresh && is_ship;
                    bus.nearmiss <= fresh && !is_ship && is_adj;
                    bus.miss <= fresh && !is_ship && !is_adj;
                    if (fresh) begin
                        fired[idx] <= 1'b1;
                        bus.shots_left <= bus.shots_left - 5'd1;
                        bus.hit_count <= bus.hit_count + {2'b0, is_ship};
                    end
                    state <= REPORT;
                end
                REPORT: state <= (bus.hit_count == 3'(SHIP_CELLS) || bus.shots_left == 5'd0) ? DONE : WAIT_SHOT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_battleship_ctrl.sv
// tb_battleship_ctrl: vector table, randomized games against a reference model, and reset corner cases.
module tb_battleship_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    battleship_if bus ();
    battleship_if bus3 ();
    battleship_ctrl u_dut (.clock(clk), .reset(rst), .bus(bus.slave));
    battleship_ctrl #(.MAX_SHOTS(3)) u_dut3 (.clock(clk), .reset(rst), .bus(bus3.slave));
    int checks = 0;
    int failures = 0;
    // reference model: board of fired cells, score and shots remaining
    bit mf [100];
    int m_hits, m_left;
    int sx [4] = '{2, 3, 6, 7};
    int sy [4] = '{9, 9, 1, 1};
    // result codes: 0 hit, 1 nearmiss, 2 miss, 3 repeat, 4 bad coordinate
    typedef struct {int x; int y; int code; int hits; int left;} vec_t;
    vec_t tbl [13];
    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", n, a, e, $time);
        end
    endtask
    function automatic int flags();
        return int'({bus.hit, bus.nearmiss, bus.miss, bus.repeat_shot, bus.bad_coord});
    endfunction
    function automatic int classify(input int x, input int y);
        int d;
        if (x > 9 || y > 9) return 4;
        if (mf[y * 10 + x]) return 3;
        for (int i = 0; i < 4; i++) if (x == sx[i] && y == sy[i]) return 0;
        for (int i = 0; i < 4; i++) begin
            d = (x > sx[i] ? x - sx[i] : sx[i] - x) + (y > sy[i] ? y - sy[i] : sy[i] - y);
            if (d == 1) return 1;
        end
        return 2;
    endfunction
    task automatic start_game();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 100; i++) mf[i] = 1'b0;
        m_hits = 0;
        m_left = 20;
        @(negedge clk);
    endtask
    task automatic fire(input int x, input int y, output int f, output int hc, output int sl);
        int w = 0;
        while (!bus.shot_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("shot_ready_wait", int'(bus.shot_ready), 1);
        bus.x = 4'(x);
        bus.y = 4'(y);
        bus.shot_valid = 1'b1;
        @(negedge clk);
        bus.shot_valid = 1'b0;
        chk("no_result_in_check", int'(bus.result_valid), 0);
        @(negedge clk);
        chk("result_at_n_plus_2", int'(bus.result_valid), 1);
        f = flags();
        hc = int'(bus.hit_count);
        sl = int'(bus.shots_left);
        @(negedge clk);
        chk("result_one_cycle", int'(bus.result_valid), 0);
    endtask
    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        int f, hc, sl, code, x, y, n, r, k;
        bus.start = 0; bus.shot_valid = 0; bus.x = 0; bus.y = 0;
        bus3.start = 0; bus3.shot_valid = 0; bus3.x = 0; bus3.y = 0;
        tbl[0]  = '{2, 9, 0, 1, 19};
        tbl[1]  = '{2, 9, 3, 1, 19};
        tbl[2]  = '{4, 9, 1, 1, 18};
        tbl[3]  = '{0, 0, 2, 1, 17};
        tbl[4]  = '{12, 3, 4, 1, 17};
        tbl[5]  = '{5, 15, 4, 1, 17};
        tbl[6]  = '{6, 2, 1, 1, 16};
        tbl[7]  = '{1, 9, 1, 1, 15};
        tbl[8]  = '{3, 9, 0, 2, 14};
        tbl[9]  = '{0, 0, 3, 2, 14};
        tbl[10] = '{6, 1, 0, 3, 13};
        tbl[11] = '{5, 5, 2, 3, 12};
        tbl[12] = '{7, 1, 0, 4, 11};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_shot_ready", int'(bus.shot_ready), 0);
        chk("reset_result_valid", int'(bus.result_valid), 0);
        chk("reset_flags", flags(), 0);
        chk("reset_hit_count", int'(bus.hit_count), 0);
        chk("reset_shots_left", int'(bus.shots_left), 0);
        chk("reset_game_over", int'(bus.game_over), 0);
        chk("reset_win", int'(bus.win), 0);
        // three-shot game on the small instance
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        chk("small_start_left", int'(bus3.shots_left), 3);
        for (int i = 0; i < 3; i++) begin
            bus3.x = 4'(i);
            bus3.y = 4'd5;
            bus3.shot_valid = 1'b1;
            @(negedge clk);
            bus3.shot_valid = 1'b0;
            @(negedge clk);
            chk("small_miss", int'(bus3.miss), 1);
            @(negedge clk);
        end
        chk("small_game_over", int'(bus3.game_over), 1);
        chk("small_win", int'(bus3.win), 0);
        chk("small_left_zero", int'(bus3.shots_left), 0);
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        chk("small_restart_left", int'(bus3.shots_left), 3);
        chk("small_restart_over", int'(bus3.game_over), 0);
        chk("small_restart_ready", int'(bus3.shot_ready), 1);
        // directed table through to a win
        start_game();
        chk("start_left", int'(bus.shots_left), 20);
        chk("start_ready", int'(bus.shot_ready), 1);
        for (int i = 0; i < 13; i++) begin
            fire(tbl[i].x, tbl[i].y, f, hc, sl);
            chk($sformatf("vec%0d_flags", i), f, 16 >> tbl[i].code);
            chk($sformatf("vec%0d_hits", i), hc, tbl[i].hits);
            chk($sformatf("vec%0d_left", i), sl, tbl[i].left);
        end
        chk("win_game_over", int'(bus.game_over), 1);
        chk("win_flag", int'(bus.win), 1);
        bus.x = 4'd0;
        bus.y = 4'd1;
        bus.shot_valid = 1'b1;
        k = 0;
        repeat (4) begin
            @(negedge clk);
            k += int'(bus.result_valid);
        end
        bus.shot_valid = 1'b0;
        chk("done_ignores_shot", k, 0);
        chk("done_holds_hits", int'(bus.hit_count), 4);
        chk("done_holds_left", int'(bus.shots_left), 11);
        // randomized games against the reference model
        for (int g = 0; g < 4; g++) begin
            start_game();
            n = 0;
            while (!(m_hits == 4 || m_left == 0) && n < 200) begin
                r = int'($urandom_range(0, 2));
                if (r == 0) begin
                    x = int'($urandom_range(0, 11));
                    y = int'($urandom_range(0, 11));
                end else if (r == 1) begin
                    k = int'($urandom_range(0, 3));
                    x = sx[k];
                    y = sy[k];
                    case ($urandom_range(0, 4))
                        1: x = x + 1;
                        2: x = x - 1;
                        3: y = y + 1;
                        4: y = y - 1;
                        default: ;
                    endcase
                end else begin
                    x = int'($urandom_range(0, 9));
                    y = int'($urandom_range(0, 9));
                end
                code = classify(x, y);
                if (code < 3) begin
                    mf[y * 10 + x] = 1'b1;
                    m_left--;
                    if (code == 0) m_hits++;
                end
                fire(x, y, f, hc, sl);
                chk("rand_flags", f, 16 >> code);
                chk("rand_hits", hc, m_hits);
                chk("rand_left", sl, m_left);
                n++;
            end
            chk("rand_game_over", int'(bus.game_over), 1);
            chk("rand_win", int'(bus.win), int'(m_hits == 4));
        end
        // reset while the shot sits in CHECK
        start_game();
        bus.x = 4'd2; bus.y = 4'd9; bus.shot_valid = 1'b1;
        @(negedge clk);
        bus.shot_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_check_ready", int'(bus.shot_ready), 0);
        chk("rst_check_rv", int'(bus.result_valid), 0);
        chk("rst_check_flags", flags(), 0);
        chk("rst_check_hits", int'(bus.hit_count), 0);
        chk("rst_check_left", int'(bus.shots_left), 0);
        chk("rst_check_over", int'(bus.game_over), 0);
        k = 0;
        repeat (4) begin
            @(negedge clk);
            k += int'(bus.result_valid);
        end
        chk("rst_check_no_pulse", k, 0);
        // reset while the result is being reported
        start_game();
        bus.x = 4'd3; bus.y = 4'd9; bus.shot_valid = 1'b1;
        @(negedge clk);
        bus.shot_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_report_rv", int'(bus.result_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_report_rv", int'(bus.result_valid), 0);
        chk("rst_report_hits", int'(bus.hit_count), 0);
        chk("rst_report_left", int'(bus.shots_left), 0);
        // reset coinciding with an accepted shot
        start_game();
        bus.x = 4'd6; bus.y = 4'd1; bus.shot_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus.shot_valid = 1'b0;
        rst = 1'b0;
        k = 0;
        repeat (4) begin
            @(negedge clk);
            k += int'(bus.result_valid);
        end
        chk("rst_accept_no_pulse", k, 0);
        chk("rst_accept_idle", int'(bus.shot_ready), 0);
        chk("rst_accept_hits", int'(bus.hit_count), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
